// File: rtl/sized_data_memory.sv
// Byte-addressed little-endian data memory with sized loads/stores and a
// valid/ready request/response handshake of fixed, parametrised latency.
module sized_data_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic [1:0]  size_q, size_d;
  addr_t       addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  mem_q [DEPTH];

  logic        commit;
  logic        c_we;
  logic        c_uns;
  logic [1:0]  c_size;
  addr_t       c_addr;
  logic [31:0] c_wdata;
  logic        c_err;
  logic [31:0] c_load;
  logic [3:0]  lane_en;
  logic [7:0]  b0, b1, b2, b3;

  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_WIDTH];

  // With single-cycle latency the commit happens on the accept edge,
  // so operands come straight from the request port.
  always_comb begin
    c_we    = we_q;
    c_uns   = uns_q;
    c_size  = size_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (state_q == IDLE) begin
      c_we    = req_we;
      c_uns   = req_unsigned;
      c_size  = req_size;
      c_addr  = req_addr[ADDR_WIDTH-1:0];
      c_wdata = req_wdata;
    end
  end

  always_comb begin
    b0      = mem_q[c_addr];
    b1      = mem_q[c_addr + addr_t'(1)];
    b2      = mem_q[c_addr + addr_t'(2)];
    b3      = mem_q[c_addr + addr_t'(3)];
    c_err   = 1'b0;
    c_load  = '0;
    lane_en = '0;
    unique case (c_size)
      2'b00: begin
        lane_en = 4'b0001;
        c_load  = {{24{~c_uns & b0[7]}}, b0};
      end
      2'b01: begin
        c_err   = c_addr[0];
        lane_en = 4'b0011;
        c_load  = {{16{~c_uns & b1[7]}}, b1, b0};
      end
      2'b10: begin
        c_err   = |c_addr[1:0];
        lane_en = 4'b1111;
        c_load  = {b3, b2, b1, b0};
      end
      default: c_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    uns_d   = uns_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          uns_d   = req_unsigned;
          size_d  = req_size;
          addr_d  = req_addr[ADDR_WIDTH-1:0];
          wdata_d = req_wdata;
          if (LATENCY == 1) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = c_err;
      rdata_d = (c_we || c_err) ? '0 : c_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Contents survive reset; only a committed, legal store writes.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) begin
          mem_q[c_addr + addr_t'(i)] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = ~reset & (state_q == IDLE);
  assign resp_valid = ~reset & (state_q == RESP);
  assign resp_rdata = reset ? '0 : rdata_q;
  assign resp_err   = ~reset & err_q;

endmodule
